led_ctrl: RTL

//  Parametrised status-LED controller; the next generation of the board LED driver.

---
 rtl/led_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/led_ctrl.sv
// Status-LED controller: per-channel off/on/blink/stretch with a shared prescaler.
// Optional build macro LED_PWM_EN adds a per-channel 4-bit duty input and a PWM gate.

module led_ctrl_lane #(
  parameter int STR_W         = 3,
  parameter int STRETCH_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       evt,
  input  logic       tick,
  input  logic       phase,
  input  logic       force_on,
  input  logic       gate,
  output logic       led
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_STRETCH = 2'b11
  } mode_e;

  logic [STR_W-1:0] str;
  logic             str_act;
  logic             on;

  assign str_act = (str != '0);

  // Counter runs in every mode so entering stretch shows any pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          str <= '0;
    else if (evt)        str <= STR_W'(STRETCH_TICKS);
    else if (tick && str_act) str <= str - 1'b1;
  end

  always_comb begin
    on = 1'b0;
    case (mode_e'(mode))
      MODE_OFF:     on = 1'b0;
      MODE_ON:      on = 1'b1;
      MODE_BLINK:   on = phase;
      MODE_STRETCH: on = str_act;
      default:      on = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 1'b0;
    else        led <= force_on | (on & gate);
  end

endmodule

module led_ctrl #(
  parameter int NUM_LEDS      = 3,
  parameter int PRE_W         = 25,
  parameter int STR_W         = 3,
  parameter int STRETCH_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NUM_LEDS-1:0] mode,
  input  logic [NUM_LEDS-1:0]   evt,
  input  logic                  force_on,
`ifdef LED_PWM_EN
  input  logic [4*NUM_LEDS-1:0] duty,
`endif
  output logic [NUM_LEDS-1:0]   led,
  output logic                  tick
);

  logic [PRE_W-1:0]    pre;
  logic                phase;
  logic [NUM_LEDS-1:0] gate;

  // tick lands in the cycle where pre has just wrapped to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      tick  <= 1'b0;
      phase <= 1'b0;
    end else begin
      pre   <= pre + 1'b1;
      tick  <= &pre;
      phase <= phase ^ tick;
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= '0;
    else        pwm <= pwm + 1'b1;
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_gate
    assign gate[i] = (pwm < duty[4*i +: 4]);
  end
`else
  assign gate = '1;
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    led_ctrl_lane #(
      .STR_W         (STR_W),
      .STRETCH_TICKS (STRETCH_TICKS)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode[2*i +: 2]),
      .evt      (evt[i]),
      .tick     (tick),
      .phase    (phase),
      .force_on (force_on),
      .gate     (gate[i]),
      .led      (led[i])
    );
  end

endmodule
